truth_table_sweeper: RTL and testbench

//   Sequential, parametrised truth-table generator for an N-input boolean function.
//   The function is a programmable LUT, latched at start (e.g. AND3 = 8'b1000_0000).

---
 rtl/truth_table_sweeper_if.sv | 24 ++
 rtl/truth_table_sweeper.sv | 128 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Row stream between the truth-table sweeper and its consumer.
// master drives row_valid/row_x/row_s; slave drives row_ready.
interface truth_table_sweeper_if #(
    parameter int N = 3
);
    logic         row_valid;
    logic         row_ready;
    logic [N-1:0] row_x;
    logic         row_s;

    modport master (
        output row_valid,
        output row_x,
        output row_s,
        input  row_ready
    );

    modport slave (
        input  row_valid,
        input  row_x,
        input  row_s,
        output row_ready
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input vector x = 0..2^N-1 of a latched N-input LUT and streams
// the rows (x, lut[x]) on a valid/ready interface, counting rows with s = 1.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         begin a sweep (sampled only when idle)
//   lut           function table, bit i = value for x == i, latched on start
//   row_if        master side of the row stream (row_valid/row_ready/row_x/row_s)
//   busy          high while sweeping and during the done cycle
//   done          one-cycle pulse after the last row is accepted
//   ones_count    accepted rows with row_s == 1, held until the next start
module truth_table_sweeper #(
    parameter  int N    = 3,
    localparam int ROWS = 2 ** N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ROWS-1:0]       lut,
    truth_table_sweeper_if.master row_if,
    output logic                  busy,
    output logic                  done,
    output logic [N:0]            ones_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [N-1:0] X_LAST = N'(ROWS - 1);

    logic [1:0]      state_q, state_d;
    logic [ROWS-1:0] lut_q, lut_d;
    logic [N-1:0]    x_q, x_d;
    logic            s_q, s_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N:0]      ones_q, ones_d;

    logic            accept;
    logic [N-1:0]    x_inc;

    always_comb begin
        state_d = state_q;
        lut_d   = lut_q;
        x_d     = x_q;
        s_d     = s_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ones_d  = ones_q;
        accept  = valid_q & row_if.row_ready;
        x_inc   = x_q + N'(1);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SWEEP;
                    lut_d   = lut;
                    x_d     = '0;
                    s_d     = lut[0];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    ones_d  = '0;
                end
            end
            S_SWEEP: begin
                if (accept) begin
                    // Count the row being handed over on this edge.
                    if (s_q) begin
                        ones_d = ones_q + (N+1)'(1);
                    end
                    if (x_q == X_LAST) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        x_d     = '0;
                        s_d     = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        x_d = x_inc;
                        s_d = lut_q[x_inc];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                x_d     = '0;
                s_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lut_q   <= '0;
            x_q     <= '0;
            s_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            lut_q   <= lut_d;
            x_q     <= x_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ones_q  <= ones_d;
        end
    end

    assign row_if.row_valid = valid_q;
    assign row_if.row_x     = x_q;
    assign row_if.row_s     = s_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign ones_count       = ones_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper at N = 3, 1 and 8.
// Expected rows are queued at start and popped on each accepted row.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start3, start1, start8;
    logic [7:0]   lut3;
    logic [1:0]   lut1;
    logic [255:0] lut8;
    logic         busy3, done3, busy1, done1, busy8, done8;
    logic [3:0]   ones3;
    logic [1:0]   ones1;
    logic [8:0]   ones8;

    truth_table_sweeper_if #(.N(3)) if3 ();
    truth_table_sweeper_if #(.N(1)) if1 ();
    truth_table_sweeper_if #(.N(8)) if8 ();

    truth_table_sweeper #(.N(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start3),
        .lut        (lut3),
        .row_if     (if3),
        .busy       (busy3),
        .done       (done3),
        .ones_count (ones3)
    );

    truth_table_sweeper #(.N(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .lut        (lut1),
        .row_if     (if1),
        .busy       (busy1),
        .done       (done1),
        .ones_count (ones1)
    );

    truth_table_sweeper #(.N(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .lut        (lut8),
        .row_if     (if8),
        .busy       (busy8),
        .done       (done8),
        .ones_count (ones8)
    );

    int checks   = 0;
    int failures = 0;
    int sb[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_rows(input logic [7:0] l);
        for (int i = 0; i < 8; i++) begin
            sb.push_back(i * 2 + int'(l[i]));
        end
    endtask

    // Called after the inputs for the coming edge are driven.
    task automatic observe3(input string tag);
        int e;
        if (if3.row_valid && if3.row_ready) begin
            chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_x"}, if3.row_x, e >> 1);
                chk({tag, "_s"}, if3.row_s, e & 1);
            end
        end
    endtask

    // mode 0: ready=1, 1: ready toggles, 2: re-start with lut=FF at x=2
    task automatic sweep3(input string tag, input logic [7:0] l,
                          input int mode, output int done_at,
                          output int ndone, output int nacc);
        push_rows(l);
        @(negedge clk);
        start3 = 1'b1;
        lut3 = l;
        if3.row_ready = 1'b1;
        chk({tag, "_idle_valid"}, if3.row_valid, 0);
        done_at = 0;
        ndone = 0;
        nacc = 0;
        for (int c = 1; c <= 40 && ndone == 0; c++) begin
            @(negedge clk);
            start3 = 1'b0;
            lut3 = 8'($urandom);
            if3.row_ready = 1'b1;
            if (mode == 1) if3.row_ready = c[0];
            if (mode == 2 && if3.row_valid && if3.row_x == 3'd2) begin
                start3 = 1'b1;
                lut3 = 8'hFF;
            end
            if (c == 1) begin
                chk({tag, "_lat_valid"}, if3.row_valid, 1);
                chk({tag, "_lat_x"}, if3.row_x, 0);
                chk({tag, "_lat_busy"}, busy3, 1);
                chk({tag, "_lat_ones"}, ones3, 0);
            end
            if (if3.row_valid && if3.row_ready) nacc++;
            observe3(tag);
            if (done3) begin
                ndone++;
                done_at = c;
                chk({tag, "_done_busy"}, busy3, 1);
                chk({tag, "_done_valid"}, if3.row_valid, 0);
                chk({tag, "_ones"}, ones3, $countones(l));
            end
        end
        if (ndone == 0) chk({tag, "_timeout"}, 0, 1);
        @(negedge clk);
        start3 = 1'b0;
        chk({tag, "_idle_busy"}, busy3, 0);
        chk({tag, "_idle_done"}, done3, 0);
        chk({tag, "_ones_hold"}, ones3, $countones(l));
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    int da, nd, na;
    int d1, d2, e1, e8, n1, n8;

    initial begin
        rst_n = 1'b0;
        start3 = 1'b0;
        start1 = 1'b0;
        start8 = 1'b0;
        lut3 = '0;
        lut1 = '0;
        lut8 = '0;
        if3.row_ready = 1'b0;
        if1.row_ready = 1'b0;
        if8.row_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", if3.row_valid, 0);
        chk("rst_x", if3.row_x, 0);
        chk("rst_s", if3.row_s, 0);
        chk("rst_busy", busy3, 0);
        chk("rst_done", done3, 0);
        chk("rst_ones", ones3, 0);
        rst_n = 1'b1;

        // AND3, ready held high
        sweep3("and3", 8'b1000_0000, 0, da, nd, na);
        chk("and3_done_at", da, 9);
        chk("and3_nacc", na, 8);

        // ready toggling, rows held when not accepted
        sweep3("tog", 8'b1110_1000, 1, da, nd, na);
        chk("tog_done_at", da, 16);
        chk("tog_nacc", na, 8);
        chk("tog_ndone", nd, 1);

        // reset at row x=4
        push_rows(8'h5A);
        @(negedge clk);
        start3 = 1'b1;
        lut3 = 8'h5A;
        if3.row_ready = 1'b1;
        na = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (if3.row_valid && if3.row_x == 3'd4) begin
                rst_n = 1'b0;
                na = 1;
                break;
            end
            observe3("rst4");
        end
        chk("rst4_reached", na, 1);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst4_valid", if3.row_valid, 0);
        chk("rst4_busy", busy3, 0);
        chk("rst4_ones", ones3, 0);
        chk("rst4_done", done3, 0);
        sb.delete();
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done3) nd++;
        end
        chk("rst4_no_done", nd, 0);
        sweep3("restart", 8'h96, 0, da, nd, na);
        chk("restart_done_at", da, 9);

        // re-start while busy is ignored
        sweep3("ign", 8'h29, 2, da, nd, na);
        chk("ign_done_at", da, 9);
        chk("ign_nacc", na, 8);

        // start held high: back-to-back sweeps
        push_rows(8'h3C);
        push_rows(8'h3C);
        @(negedge clk);
        start3 = 1'b1;
        lut3 = 8'h3C;
        if3.row_ready = 1'b1;
        nd = 0;
        d1 = 0;
        d2 = 0;
        for (int c = 1; c <= 60 && nd < 2; c++) begin
            @(negedge clk);
            if (nd > 0 && c == d1 + 1) chk("b2b_gap_busy", busy3, 0);
            if (nd > 0 && c == d1 + 2) begin
                chk("b2b_restart_valid", if3.row_valid, 1);
                chk("b2b_restart_x", if3.row_x, 0);
                chk("b2b_ones_clr", ones3, 0);
            end
            observe3("b2b");
            if (done3) begin
                nd++;
                if (nd == 1) d1 = c;
                else d2 = c;
                chk("b2b_ones", ones3, 4);
                if (nd == 2) start3 = 1'b0;
            end
        end
        chk("b2b_ndone", nd, 2);
        chk("b2b_spacing", d2 - d1, 10);
        chk("b2b_sb_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
        chk("b2b_stopped", busy3, 0);

        // N=1 and N=8 sweeps run side by side
        @(negedge clk);
        start1 = 1'b1;
        lut1 = 2'b10;
        start8 = 1'b1;
        lut8 = '1;
        if1.row_ready = 1'b1;
        if8.row_ready = 1'b1;
        e1 = 0;
        e8 = 0;
        n1 = 0;
        n8 = 0;
        for (int c = 1; c <= 300 && (n1 == 0 || n8 == 0); c++) begin
            @(negedge clk);
            start1 = 1'b0;
            start8 = 1'b0;
            if (if1.row_valid) begin
                chk("n1_x", if1.row_x, e1);
                chk("n1_s", if1.row_s, lut1[e1]);
                e1++;
            end
            if (done1) begin
                n1++;
                chk("n1_done_at", c, 3);
                chk("n1_rows", e1, 2);
                chk("n1_ones", ones1, 1);
            end
            if (if8.row_valid) begin
                chk("n8_x", if8.row_x, e8);
                chk("n8_s", if8.row_s, 1);
                e8++;
            end
            if (done8) begin
                n8++;
                chk("n8_rows", e8, 256);
                chk("n8_ones", ones8, 9'h100);
            end
        end
        chk("n1_ndone", n1, 1);
        chk("n8_ndone", n8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
